// File: rtl/stream_merge_pkg.sv
// Shared types and helpers for the two-input stream merger.
// The source tag doubles as the round-robin grant encoding.
package stream_merge_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    function automatic int unsigned fifo_depth(input int unsigned a_width);
        return 32'd1 << a_width;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with power-of-two depth and an occupancy count.
// The count is one bit wider than the pointers so that full and empty are unambiguous.
module stream_fifo
    import stream_merge_pkg::*;
#(
    parameter int unsigned D_WIDTH = 6,
    parameter int unsigned A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [D_WIDTH-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    localparam int unsigned Depth = fifo_depth(A_WIDTH);

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic [D_WIDTH-1:0] mem_q [Depth];
    logic               push_en;
    logic               pop_en;

    assign full     = (count_q == (A_WIDTH + 1)'(Depth));
    assign empty    = (count_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + A_WIDTH'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (A_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (A_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/stream_merge_2to1.sv
// Two-input valid/ready merger: per-input FIFOs drained round-robin into one
// registered output stage that also reports which input each beat came from.
module stream_merge_2to1
    import stream_merge_pkg::*;
#(
    parameter int unsigned D_WIDTH = 6,
    parameter int unsigned A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid_a,
    output logic               up_ready_a,
    input  logic [D_WIDTH-1:0] up_data_a,
    input  logic               up_valid_b,
    output logic               up_ready_b,
    input  logic [D_WIDTH-1:0] up_data_b,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_src
);

    logic               full_a, empty_a, pop_a;
    logic               full_b, empty_b, pop_b;
    logic [D_WIDTH-1:0] data_a, data_b;
    logic               can_load, load;
    src_t               grant;

    logic               down_valid_q, down_valid_d;
    logic [D_WIDTH-1:0] down_data_q, down_data_d;
    src_t               down_src_q, down_src_d;
    src_t               last_grant_q, last_grant_d;

    // Ready depends only on FIFO occupancy, never on down_ready.
    assign up_ready_a = rst && !full_a;
    assign up_ready_b = rst && !full_b;

    stream_fifo #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (up_valid_a && up_ready_a),
        .push_data (up_data_a),
        .pop       (pop_a),
        .pop_data  (data_a),
        .full      (full_a),
        .empty     (empty_a)
    );

    stream_fifo #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (up_valid_b && up_ready_b),
        .push_data (up_data_b),
        .pop       (pop_b),
        .pop_data  (data_b),
        .full      (full_b),
        .empty     (empty_b)
    );

    always_comb begin
        can_load     = !down_valid_q || down_ready;
        load         = can_load && (!empty_a || !empty_b);
        grant        = SRC_A;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_src_d   = down_src_q;
        last_grant_d = last_grant_q;

        if (!empty_a && !empty_b) begin
            grant = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
        end else if (empty_a) begin
            grant = SRC_B;
        end

        pop_a = load && (grant == SRC_A);
        pop_b = load && (grant == SRC_B);

        // With nothing buffered the stage empties but keeps its last data and tag.
        if (can_load) begin
            down_valid_d = load;
        end
        if (load) begin
            down_data_d  = (grant == SRC_A) ? data_a : data_b;
            down_src_d   = grant;
            last_grant_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_src_q   <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_src_q   <= down_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_src   = down_src_q;

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Self-checking bench for stream_merge_2to1: a queue-based reference model feeds a
// scoreboard that a negedge monitor drains on every downstream handshake.
module tb_stream_merge_2to1;

    localparam int D_WIDTH = 6;
    localparam int A_WIDTH = 2;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst;
    logic               up_valid_a, up_ready_a;
    logic [D_WIDTH-1:0] up_data_a;
    logic               up_valid_b, up_ready_b;
    logic [D_WIDTH-1:0] up_data_b;
    logic               down_valid, down_ready;
    logic [D_WIDTH-1:0] down_data;
    logic               down_src;

    stream_merge_2to1 #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid_a (up_valid_a),
        .up_ready_a (up_ready_a),
        .up_data_a  (up_data_a),
        .up_valid_b (up_valid_b),
        .up_ready_b (up_ready_b),
        .up_data_b  (up_data_b),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_src   (down_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: buffered beats per input plus the output slot.
    int qa[$];
    int qb[$];
    bit mv;
    int md, ms, lg;
    bit acc_a_evt, acc_b_evt;
    int exp_q[$];
    int log_q[$];

    // Stimulus control.
    int src_a_q[$];
    int src_b_q[$];
    int rate_a  = 100;
    int rate_b  = 100;
    int dr_mode = 0;
    int dut_acc_a = 0;
    int dut_acc_b = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int g;
        if (!rst) begin
            qa.delete();
            qb.delete();
            exp_q.delete();
            mv = 0; md = 0; ms = 0; lg = 1;
            acc_a_evt = 0; acc_b_evt = 0;
            return;
        end
        acc_a_evt = up_valid_a && (qa.size() < DEPTH);
        acc_b_evt = up_valid_b && (qb.size() < DEPTH);
        if (!mv || down_ready) begin
            if (qa.size() == 0 && qb.size() == 0) begin
                mv = 0;
            end else begin
                if (qa.size() != 0 && qb.size() != 0) g = 1 - lg;
                else g = (qa.size() != 0) ? 0 : 1;
                md = (g == 0) ? qa.pop_front() : qb.pop_front();
                mv = 1; ms = g; lg = g;
                exp_q.push_back((g << 8) | md);
            end
        end
        if (acc_a_evt) qa.push_back(int'(up_data_a));
        if (acc_b_evt) qb.push_back(int'(up_data_b));
    endtask

    initial begin
        mv = 0; md = 0; ms = 0; lg = 1; acc_a_evt = 0; acc_b_evt = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare against the model away from the clock edge.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst down_valid", int'(down_valid), 0);
                check("rst down_data", int'(down_data), 0);
                check("rst down_src", int'(down_src), 0);
                check("rst up_ready_a", int'(up_ready_a), 0);
                check("rst up_ready_b", int'(up_ready_b), 0);
            end else begin
                check("down_valid", int'(down_valid), int'(mv));
                check("down_data", int'(down_data), md);
                check("down_src", int'(down_src), ms);
                check("up_ready_a", int'(up_ready_a), int'(qa.size() < DEPTH));
                check("up_ready_b", int'(up_ready_b), int'(qb.size() < DEPTH));
                if (up_valid_a && up_ready_a) dut_acc_a++;
                if (up_valid_b && up_ready_b) dut_acc_b++;
                if (down_valid && down_ready) begin
                    e = (int'(down_src) << 8) | int'(down_data);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard: unexpected beat 0x%0h, expected none at %0t",
                                 e, $time);
                    end else begin
                        check("scoreboard", e, exp_q.pop_front());
                    end
                    log_q.push_back(e);
                end
            end
        end
    end

    // Driver: holds a beat until accepted, inserts random gaps per stream.
    initial begin
        up_valid_a = 0; up_valid_b = 0; up_data_a = '0; up_data_b = '0; down_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (acc_a_evt && src_a_q.size() > 0) void'(src_a_q.pop_front());
            if (acc_b_evt && src_b_q.size() > 0) void'(src_b_q.pop_front());
            if (src_a_q.size() > 0 &&
                ((up_valid_a && !acc_a_evt) || $urandom_range(99) < rate_a)) begin
                up_valid_a = 1; up_data_a = D_WIDTH'(src_a_q[0]);
            end else begin
                up_valid_a = 0; up_data_a = D_WIDTH'($urandom);
            end
            if (src_b_q.size() > 0 &&
                ((up_valid_b && !acc_b_evt) || $urandom_range(99) < rate_b)) begin
                up_valid_b = 1; up_data_b = D_WIDTH'(src_b_q[0]);
            end else begin
                up_valid_b = 0; up_data_b = D_WIDTH'($urandom);
            end
            case (dr_mode)
                0:       down_ready = 1;
                1:       down_ready = 0;
                default: down_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 0;
        src_a_q.delete();
        src_b_q.delete();
        #1;
        check("async down_valid", int'(down_valid), 0);
        check("async down_data", int'(down_data), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1;
        log_q.delete();
    endtask

    task automatic drain(input int max_cycles);
        int t = 0;
        while ((src_a_q.size() != 0 || src_b_q.size() != 0 || qa.size() != 0 ||
                qb.size() != 0 || mv) && t < max_cycles) begin
            @(posedge clk);
            t++;
        end
        if (t >= max_cycles) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: timeout after %0d cycles, expected empty", t);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, " count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) check(name, log_q[i], exp[i]);
    endtask

    initial begin
        int e[$];
        int got_a[$];
        int got_b[$];
        int sent_a[$];
        int sent_b[$];
        int base;

        // Reset
        rst = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset down_valid", int'(down_valid), 0);
        check("reset up_ready_a", int'(up_ready_a), 0);
        rst = 1;
        @(negedge clk);
        check("post-reset up_ready_a", int'(up_ready_a), 1);
        check("post-reset up_ready_b", int'(up_ready_b), 1);

        // Single stream
        @(posedge clk); #2;
        src_a_q = '{'h05, 'h06, 'h07};
        drain(100);
        e = '{'h05, 'h06, 'h07};
        check_log("single stream", e);

        // Fair interleave from a fresh last_grant
        do_reset();
        src_a_q = '{'h01, 'h02, 'h03, 'h04};
        src_b_q = '{'h21, 'h22, 'h23, 'h24};
        drain(100);
        e = '{'h001, 'h121, 'h002, 'h122, 'h003, 'h123, 'h004, 'h124};
        check_log("interleave", e);

        // Backpressure and full
        do_reset();
        dr_mode = 1;
        base = dut_acc_a;
        src_a_q = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
        repeat (12) @(posedge clk);
        #2;
        check("full accept count", dut_acc_a - base, 5);
        check("full up_ready_a", int'(up_ready_a), 0);
        check("stall down_data", int'(down_data), 'h10);
        check("stall down_valid", int'(down_valid), 1);
        dr_mode = 0;
        drain(100);
        e = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
        check_log("backpressure", e);

        // Reset mid-operation with both FIFOs holding beats
        do_reset();
        dr_mode = 1;
        src_a_q = '{'h01, 'h02, 'h03, 'h04};
        src_b_q = '{'h21, 'h22, 'h23};
        repeat (8) @(posedge clk);
        #2;
        check("pre-reset down_valid", int'(down_valid), 1);
        do_reset();
        dr_mode = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post-flush down_valid", int'(down_valid), 0);
        end
        check("post-flush beats", log_q.size(), 0);

        // Starvation: one A beat among a continuous B stream
        do_reset();
        for (int i = 0; i < 12; i++) src_b_q.push_back('h30 + i);
        repeat (3) @(posedge clk);
        #2;
        src_a_q.push_back('h3F);
        drain(200);
        got_a.delete(); got_b.delete();
        foreach (log_q[i]) begin
            if (log_q[i] >> 8) got_b.push_back(log_q[i] & 'h3F);
            else got_a.push_back(log_q[i]);
        end
        check("starve A count", got_a.size(), 1);
        if (got_a.size() == 1) check("starve A data", got_a[0], 'h3F);
        check("starve B count", got_b.size(), 12);
        for (int i = 0; i < got_b.size(); i++) check("starve B order", got_b[i], 'h30 + i);

        // Randomized traffic with random backpressure
        do_reset();
        sent_a.delete(); sent_b.delete();
        for (int i = 0; i < 150; i++) begin
            sent_a.push_back(int'($urandom_range(63)));
            sent_b.push_back(int'($urandom_range(63)));
        end
        rate_a = int'($urandom_range(100, 20));
        rate_b = int'($urandom_range(100, 20));
        dr_mode = 2;
        src_a_q = sent_a;
        src_b_q = sent_b;
        drain(6000);
        dr_mode = 0;
        got_a.delete(); got_b.delete();
        foreach (log_q[i]) begin
            if (log_q[i] >> 8) got_b.push_back(log_q[i] & 'h3F);
            else got_a.push_back(log_q[i]);
        end
        check("random A count", got_a.size(), 150);
        check("random B count", got_b.size(), 150);
        for (int i = 0; i < got_a.size() && i < 150; i++) check("random A order", got_a[i], sent_a[i]);
        for (int i = 0; i < got_b.size() && i < 150; i++) check("random B order", got_b[i], sent_b[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_merge_2to1.md
Name: stream_merge_2to1

Overview:
- Two-input valid/ready stream merger: the opposite direction of the team's one-to-two stream splitter (single upstream fanned to down_*_a / down_*_b).
- Each upstream port has a small FIFO of depth 2**A_WIDTH.
- A round-robin arbiter drains both FIFOs into one registered downstream port, which also carries a source tag.
- Used wherever two producer streams share one consumer.

Parameters:
- D_WIDTH, 6, data width of every stream in bits.
- A_WIDTH, 2, FIFO address width; per-input FIFO depth = 2**A_WIDTH (default 4).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- up_valid_a  input  1  stream A beat valid.
- up_ready_a  output  1  stream A FIFO can accept a beat.
- up_data_a  input  D_WIDTH  stream A data.
- up_valid_b  input  1  stream B beat valid.
- up_ready_b  output  1  stream B FIFO can accept a beat.
- up_data_b  input  D_WIDTH  stream B data.
- down_valid  output  1  merged beat valid.
- down_ready  input  1  consumer accepts beat.
- down_data  output  D_WIDTH  merged data.
- down_src  output  1  source of current beat: 0 = A, 1 = B.

Behaviour:
- Reset:
  - rst low immediately clears: both FIFOs (pointers/counts), down_valid=0, down_data=0, down_src=0, last_grant=B.
  - up_ready_a/b are 0 while rst is low.
- Upstream handshake:
  - Beat is written on the rising edge where up_valid_x && up_ready_x.
  - up_ready_x = rst && (FIFO_x count != 2**A_WIDTH).
  - No write occurs when full; up_valid_x may stay high.
  - Data order within each stream is preserved.
- Output register load:
  - Condition: (!down_valid || down_ready) && (FIFO_a or FIFO_b non-empty).
  - Popping the chosen FIFO and loading down_data/down_src/down_valid=1 happen on the same edge.
  - If the load condition holds but both FIFOs are empty: when down_ready, down_valid drops to 0; down_data and down_src hold their last value.
- Arbitration:
  - Only A non-empty -> A. Only B non-empty -> B.
  - Both non-empty -> the port that is not last_grant.
  - last_grant updates to the granted port on every load.
  - After reset, A wins the first tie.
- Latency:
  - A beat accepted upstream at edge N can appear on down_valid after edge N+1 at the earliest (2-cycle minimum).
  - No combinational path from any up_* input to any down_* output, and none from down_ready to up_ready_x.
- Throughput: one beat per cycle sustained while down_ready=1 and any FIFO is non-empty.
- Stability: while down_valid && !down_ready, down_data and down_src must not change.
- Capacity: maximum buffered beats = 2*(2**A_WIDTH) + 1 (both FIFOs plus the output register).
- Pointer wrap-around:
  - Read/write pointers are A_WIDTH bits and wrap modulo depth.
  - Count is A_WIDTH+1 bits.
- Simultaneous push and pop on the same FIFO in one cycle: count unchanged, both operations take effect.
- Reset mid-operation: all buffered beats are discarded; nothing stale appears after rst rises.

Decomposition:
- Package stream_merge_pkg:
  - typedef src_t (1-bit enum SRC_A=0, SRC_B=1).
  - Localparam function for depth = 2**A_WIDTH.
- Sub-module stream_fifo:
  - Parameters D_WIDTH, A_WIDTH; same clk/rst.
  - Ports: push, push_data, pop, pop_data, full, empty.
  - Instantiated twice.
- Arbiter and output register live in the top module.

Test Plan (D_WIDTH=6, A_WIDTH=2):
1. Reset:
   - Stimulus: hold rst=0 for 3 cycles.
   - Response: down_valid=0, down_data=0, down_src=0, up_ready_a/b=0; after rst=1, up_ready_a=up_ready_b=1.
2. Single stream:
   - Stimulus: down_ready=1; send A beats 0x05, 0x06, 0x07 on consecutive cycles.
   - Response: down_data 0x05, 0x06, 0x07 on consecutive cycles, down_src=0, first down_valid 2 edges after the first accept.
3. Fair interleave:
   - Stimulus: down_ready=1; A sends 0x01..0x04 and B sends 0x21..0x24 on the same cycles.
   - Response: output 0x01, 0x21, 0x02, 0x22, 0x03, 0x23, 0x04, 0x24 with down_src alternating 0, 1.
4. Backpressure and full:
   - Stimulus: down_ready=0; push 6 A beats 0x10..0x15.
   - Response:
     - Exactly 5 beats are accepted; up_ready_a=0 from the edge after the 5th accept.
     - down_data stays 0x10 throughout.
     - After down_ready=1: 0x10..0x14 emerge in order, then 0x15 once up_ready_a reasserts.
5. Reset mid-operation:
   - Stimulus: 3 beats buffered in each FIFO with down_valid=1; assert rst=0 asynchronously between edges.
   - Response: down_valid falls without waiting for clk; after release, with no new input, down_valid stays 0 for 10 cycles.
6. Starvation check:
   - Stimulus: B streams continuously (0x30 upward); A sends a single beat 0x3F.
   - Response: 0x3F (down_src=0) appears within 2 output beats of reaching the FIFO head; B order is intact.
